// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite renderer defaults and colour word type
package sprite_pkg;

  localparam int SPR_W_DEF   = 16;
  localparam int SPR_H_DEF   = 16;
  localparam int COLOR_W_DEF = 8;
  localparam logic [3*COLOR_W_DEF-1:0] TRANSP_DEF = 24'hFFFFFF;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sprite_anim_ctr.sv
// rtl/sprite_anim_ctr.sv - animation frame counter stepped by vertical-blank pulses
module sprite_anim_ctr #(
  parameter int NUM_FRAMES = 4,
  parameter int FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_start_i,
  input  logic          anim_en_i,
  input  logic [7:0]    anim_div_i,
  output logic [FW-1:0] frame_idx_o
);

  logic [7:0]    tick_q,  tick_d;
  logic [FW-1:0] frame_q, frame_d;

  // Equality (not >=) keeps a lowered divider from stepping early; tick wraps at 255.
  always_comb begin
    tick_d  = tick_q;
    frame_d = frame_q;
    if (frame_start_i && anim_en_i) begin
      if (tick_q == anim_div_i) begin
        tick_d  = '0;
        frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        tick_d = tick_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign frame_idx_o = frame_q;

endmodule

// File: rtl/sprite_anim_rend.sv
// rtl/sprite_anim_rend.sv - animated sprite renderer: hit test, ROM address, colour pipeline
module sprite_anim_rend
  import sprite_pkg::*;
#(
  parameter int SPR_W      = SPR_W_DEF,
  parameter int SPR_H      = SPR_H_DEF,
  parameter int NUM_FRAMES = 4,
  parameter int ROM_LAT    = 1,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter logic [3*COLOR_W-1:0] TRANSP = TRANSP_DEF
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [9:0]                                  x,
  input  logic [8:0]                                  y,
  input  logic [9:0]                                  pos_x,
  input  logic [8:0]                                  pos_y,
  input  logic                                        frame_start,
  input  logic                                        anim_en,
  input  logic [7:0]                                  anim_div,
  input  logic                                        flip_h,
  output logic [$clog2(NUM_FRAMES*SPR_W*SPR_H)-1:0]   rom_addr,
  input  logic [3*COLOR_W-1:0]                        rom_data,
  output logic                                        pix,
  output logic [COLOR_W-1:0]                          r,
  output logic [COLOR_W-1:0]                          g,
  output logic [COLOR_W-1:0]                          b
);

  localparam int AW = $clog2(NUM_FRAMES * SPR_W * SPR_H);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [FW-1:0] frame_idx;

  sprite_anim_ctr #(
    .NUM_FRAMES (NUM_FRAMES),
    .FW         (FW)
  ) u_anim_ctr (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start_i (frame_start),
    .anim_en_i     (anim_en),
    .anim_div_i    (anim_div),
    .frame_idx_o   (frame_idx)
  );

  // Shadow origin/flip change only at vertical blank so a frame never tears.
  logic [9:0] sx0_q;
  logic [8:0] sy0_q;
  logic       flip_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sx0_q  <= '0;
      sy0_q  <= '0;
      flip_q <= 1'b0;
    end else if (frame_start) begin
      sx0_q  <= pos_x;
      sy0_q  <= pos_y;
      flip_q <= flip_h;
    end
  end

  // Widened end bounds clip at the screen edge instead of wrapping to column/row 0.
  logic [10:0]   x_end;
  logic [9:0]    y_end;
  logic          hit;
  logic [9:0]    ox;
  logic [8:0]    oy;
  logic [9:0]    col;
  logic [AW-1:0] addr_d;

  always_comb begin
    x_end  = {1'b0, sx0_q} + 11'(SPR_W);
    y_end  = {1'b0, sy0_q} + 10'(SPR_H);
    hit    = (x >= sx0_q) && ({1'b0, x} < x_end) &&
             (y >= sy0_q) && ({1'b0, y} < y_end);
    ox     = x - sx0_q;
    oy     = y - sy0_q;
    col    = flip_q ? (10'(SPR_W - 1) - ox) : ox;
    addr_d = '0;
    if (hit) begin
      addr_d = AW'(frame_idx) * AW'(SPR_W * SPR_H) + AW'(oy) * AW'(SPR_W) + AW'(col);
    end
  end

  logic [AW-1:0]      rom_addr_q;
  logic               hit_q;
  logic [ROM_LAT-1:0] vld_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      vld_q      <= '0;
    end else begin
      rom_addr_q <= addr_d;
      hit_q      <= hit;
      vld_q[0]   <= hit_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign rom_addr = rom_addr_q;

  // vld_q's last stage lines up with the ROM word fetched for the same pixel.
  logic               pix_d;
  logic               pix_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  assign pix_d = vld_q[ROM_LAT-1] && (rom_data != TRANSP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      pix_q <= pix_d;
      r_q   <= pix_d ? rom_data[3*COLOR_W-1:2*COLOR_W] : '0;
      g_q   <= pix_d ? rom_data[2*COLOR_W-1:COLOR_W]   : '0;
      b_q   <= pix_d ? rom_data[COLOR_W-1:0]           : '0;
    end
  end

  assign pix = pix_q;
  assign r   = r_q;
  assign g   = g_q;
  assign b   = b_q;

endmodule

// File: tb/tb_sprite_anim_rend.sv
// tb/tb_sprite_anim_rend.sv - scoreboard bench for sprite_anim_rend
module tb_sprite_anim_rend;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [9:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;
  logic        frame_start = 1'b0;
  logic        anim_en = 1'b0;
  logic [7:0]  anim_div = '0;
  logic        flip_h = 1'b0;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        pix;
  logic [7:0]  r, g, b;

  sprite_anim_rend #(.ROM_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .frame_start(frame_start), .anim_en(anim_en), .anim_div(anim_div), .flip_h(flip_h),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix(pix), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  rgb_t mem [1024];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          addr;
    logic        pix;
    logic [23:0] rgb;
  } exp_t;

  exp_t qa[$];
  exp_t qp[$];
  int n_checks = 0;
  int n_err = 0;

  // reference state, updated as frame_start pulses are driven
  int m_sx = 0, m_sy = 0, m_frame = 0, m_tick = 0;
  bit m_flip = 0;
  // pending input settings, applied on the next driven cycle
  int p_pos_x = 0, p_pos_y = 0, p_div = 0;
  bit p_flip = 0, p_en = 0;

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      n_checks++;
      assert (rom_addr === 10'(e.addr)) else begin
        n_err++;
        $error("FAIL rom_addr cyc=%0d got %0d exp %0d", cyc, rom_addr, e.addr);
      end
    end
    if (qp.size() > 0 && qp[0].due == cyc) begin
      e = qp.pop_front();
      n_checks++;
      assert ({pix, r, g, b} === {e.pix, e.rgb}) else begin
        n_err++;
        $error("FAIL pix_rgb cyc=%0d got pix=%0b rgb=%h exp pix=%0b rgb=%h",
               cyc, pix, {r, g, b}, e.pix, e.rgb);
      end
    end
  end

  task automatic drive(input int xx, input int yy, input bit fs);
    exp_t ea, ep;
    bit   h;
    int   col, a;
    x = 10'(xx); y = 9'(yy); frame_start = fs;
    pos_x = 10'(p_pos_x); pos_y = 9'(p_pos_y); flip_h = p_flip;
    anim_en = p_en; anim_div = 8'(p_div);
    h   = (xx >= m_sx) && (xx < m_sx + 16) && (yy >= m_sy) && (yy < m_sy + 16);
    col = m_flip ? 15 - (xx - m_sx) : (xx - m_sx);
    a   = h ? m_frame * 256 + (yy - m_sy) * 16 + col : 0;
    ea.due = cyc + 1; ea.addr = a; ea.pix = 1'b0; ea.rgb = '0;
    ep.due = cyc + 3; ep.addr = 0;
    ep.pix = h && (mem[a] != 24'hFFFFFF);
    ep.rgb = ep.pix ? mem[a] : 24'h0;
    qa.push_back(ea);
    qp.push_back(ep);
    if (fs) begin
      if (p_en) begin
        if (m_tick == p_div) begin
          m_tick  = 0;
          m_frame = (m_frame == 3) ? 0 : m_frame + 1;
        end else begin
          m_tick = (m_tick + 1) % 256;
        end
      end
      m_sx = p_pos_x; m_sy = p_pos_y; m_flip = p_flip;
    end
  endtask

  task automatic step(input int xx, input int yy, input bit fs);
    @(posedge clk); #1;
    drive(xx, yy, fs);
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    assert ({pix, r, g, b, rom_addr} === 35'h0) else begin
      n_err++;
      $error("FAIL %s got pix=%0b rgb=%h addr=%0d exp all 0", tag, pix, {r, g, b}, rom_addr);
    end
  endtask

  // Releases reset and drives a pixel; the three output slots before it must stay blank.
  task automatic release_step(input int xx, input int yy);
    exp_t z;
    @(posedge clk); #1;
    reset_n = 1'b1;
    z.addr = 0; z.pix = 1'b0; z.rgb = '0;
    z.due = cyc; qa.push_back(z);
    for (int k = 0; k < 3; k++) begin
      z.due = cyc + k; qp.push_back(z);
    end
    drive(xx, yy, 1'b0);
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_flip = 0; m_frame = 0; m_tick = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = rgb_t'(24'($urandom));
    mem[0]   = 24'h123456;
    mem[5]   = 24'hFFFFFF;
    mem[256] = 24'hFFFFFF;
    mem[15]  = 24'hABCDEF;

    repeat (2) @(posedge clk);
    #1 check_zero("reset_state");
    release_step(0, 0);
    step(15, 15, 0);
    step(16, 0, 0);

    // origin (100,50) latched by frame_start
    p_pos_x = 100; p_pos_y = 50;
    step(300, 300, 1);
    step(100, 50, 0);
    step(105, 50, 0);
    step(116, 50, 0);
    step(99, 50, 0);
    step(115, 65, 0);
    step(100, 66, 0);
    step(107, 58, 0);

    // horizontal mirror
    p_flip = 1;
    step(100, 50, 1);
    step(100, 50, 0);
    step(115, 50, 0);
    step(103, 60, 0);

    // right-edge clipping
    p_flip = 0; p_pos_x = 630;
    step(300, 300, 1);
    step(635, 50, 0);
    for (int i = 0; i <= 5; i++) step(i, 50, 0);
    step(645, 51, 0);
    step(646, 51, 0);

    // origin request without frame_start is ignored
    p_pos_x = 200;
    step(635, 52, 0);
    step(200, 52, 0);
    step(639, 52, 1);
    step(200, 52, 0);

    // animation: step every third pulse
    p_pos_x = 100; p_pos_y = 50;
    step(300, 300, 1);
    p_en = 1; p_div = 2;
    for (int i = 0; i < 12; i++) begin
      step(100, 50, 1);
      step(101, 50, 0);
    end

    // lowered divider below tick wraps through 255 before stepping
    p_div = 5;
    for (int i = 0; i < 3; i++) step(102, 51, 1);
    p_div = 1;
    for (int i = 0; i < 256; i++) step(100 + (i % 16), 50 + (i % 7), 1);

    // disabled animation holds
    p_en = 0;
    for (int i = 0; i < 5; i++) begin
      step(104, 53, 1);
      step(104, 53, 0);
    end
    p_en = 1; p_div = 0;
    step(110, 60, 1);
    step(110, 60, 0);

    // mid-line reset discards in-flight pixels
    step(100, 50, 0);
    step(110, 55, 0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1 check_zero("async_reset");
    qa.delete(); qp.delete();
    model_reset();
    p_pos_x = 0; p_pos_y = 0; p_flip = 0; p_en = 0; p_div = 0;
    @(posedge clk); #1 check_zero("reset_hold");
    release_step(3, 4);
    step(0, 0, 0);
    step(20, 20, 0);

    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    assert (qa.size() == 0 && qp.size() == 0) else begin
      n_err++;
      $error("FAIL drain got qa=%0d qp=%0d exp 0", qa.size(), qp.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_anim_rend.md
SPRITE_ANIM_REND -- requirements
Module: sprite_anim_rend

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- NUM_FRAMES, 4, animation frames stored in the sprite ROM.
- ROM_LAT, 1, sprite ROM read latency in cycles (>=1).
- COLOR_W, 8, bits per colour channel.
- TRANSP, 24'hFFFFFF, transparent colour key, compared on the full 3*COLOR_W word.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- x, in, 10, current VGA pixel X.
- y, in, 9, current VGA pixel Y.
- pos_x, in, 10, requested sprite origin X.
- pos_y, in, 9, requested sprite origin Y.
- frame_start, in, 1, one-cycle pulse at vertical blank.
- anim_en, in, 1, enables animation advance.
- anim_div, in, 8, number of extra frame_start pulses per animation step.
- flip_h, in, 1, requested horizontal mirror.
- rom_addr, out, AW = clog2(NUM_FRAMES*SPR_W*SPR_H), sprite ROM address.
- rom_data, in, 3*COLOR_W, ROM word {R,G,B}, valid ROM_LAT cycles after rom_addr.
- pix, out, 1, sprite owns this pixel.
- r, g, b, out, COLOR_W each, sprite colour; 0 when pix=0.

Function
REQ-003 The block SHALL latch pos_x, pos_y and flip_h into shadow registers only on cycles with frame_start=1; the values take effect from the following cycle, so a sprite never tears mid-frame.
REQ-004 Hit SHALL be x>=sx0 && x<sx0+SPR_W && y>=sy0 && y<sy0+SPR_H, using shadow origin sx0/sy0 and 11-/10-bit sums so sprites near the right/bottom edge are clipped, never wrapped to column/row 0.
REQ-005 Offsets SHALL be ox=x-sx0 and oy=y-sy0, and col = flip ? SPR_W-1-ox : ox.
REQ-006 rom_addr SHALL be a register loaded each cycle with frame_idx*SPR_W*SPR_H + oy*SPR_W + col when hit, else 0.
REQ-007 Hit SHALL be delayed through a ROM_LAT-stage valid pipeline aligned to rom_data.
REQ-008 Outputs SHALL be registered: pix = delayed hit && rom_data!=TRANSP; r/g/b = rom_data fields when pix, else 0.
REQ-009 Total latency from x/y to pix/r/g/b SHALL be ROM_LAT+2 cycles, with one result per cycle and no stalls.
REQ-010 Animation counter tick_cnt (8 bit) SHALL update only on frame_start with anim_en=1: if tick_cnt==anim_div then tick_cnt<=0 and frame_idx<=(frame_idx==NUM_FRAMES-1)?0:frame_idx+1, else tick_cnt<=tick_cnt+1.
REQ-011 With anim_div=0, frame_idx SHALL advance on every frame_start.
REQ-012 With anim_en=0, tick_cnt and frame_idx SHALL hold.
REQ-013 If anim_div is lowered below tick_cnt, the next enabled frame_start SHALL increment tick_cnt, wrapping at 255 to 0 (no premature step).
REQ-014 A pixel presented on the same cycle as frame_start SHALL use the pre-update frame_idx and shadow registers.

Reset
REQ-015 While reset_n=0, asynchronously: pix, r, g, b, rom_addr, the valid pipeline, tick_cnt and frame_idx SHALL be 0; shadow origin SHALL be (0,0); shadow flip SHALL be 0.
REQ-016 Reset asserted mid-line SHALL discard in-flight pixels; after release, pix SHALL remain 0 until a new hit has traversed the full pipeline.

Structure
REQ-017 Package sprite_pkg SHALL hold the default SPR_W/SPR_H/COLOR_W/TRANSP constants and an rgb_t struct {r,g,b}, shared with the other renderers.
REQ-018 Animation counting (REQ-010 to REQ-013) SHALL be a sub-module sprite_anim_ctr; the hit test, address and pipeline logic stay in the top level.

Verification
REQ-019 Defaults, ROM_LAT=1, pos=(100,50) latched by frame_start, ROM word at address 0 = 24'h123456; x=100,y=50 -> pix=1, r=12 g=34 b=56 exactly 3 cycles later.
REQ-020 Address 5 = 24'hFFFFFF; x=105,y=50 -> pix=0, rgb=0; x=116 -> rom_addr=0 and pix=0.
REQ-021 flip_h=1 latched; x=100,y=50 -> rom_addr=15; x=115 -> rom_addr=0.
REQ-022 pos_x=630: x=635 -> pix per ROM data; x=0..5 -> pix=0 (no wrap).
REQ-023 anim_en=1, anim_div=2, 12 frame_start pulses -> frame_idx steps after pulses 3, 6, 9, 12 and reads 0 after 12; rom_addr base follows 0, 256, 512, 768, 0.
REQ-024 pos_x changed without frame_start -> hit unchanged; reset_n pulsed mid-line -> all outputs 0 immediately and frame_idx=0.
